md_sequencer: RTL and testbench

- Multi-cycle multiply/divide controller beside the single-cycle execute ALU.
- Sequences iterative shift-add multiply and restoring divide for mult/multu/div/divu.
- Owns the HI/LO registers, services mthi/mtlo and mfhi/mflo, and raises a pipeline stall while the shared iteration datapath is occupied.

---
 rtl/md_sequencer_if.sv | 37 +++
 rtl/md_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_md_sequencer.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/md_sequencer_if.sv
// ============================================================================
// Module   : md_sequencer_if
// Purpose  : Pipeline-side handshake and HI/LO bus of the multiply/divide
//            sequencer; master is the pipeline, slave is the sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface md_sequencer_if #(
  parameter int WIDTH = 32
);
  logic             Md_start;
  logic [1:0]       Md_op;
  logic [WIDTH-1:0] Read_data_1;
  logic [WIDTH-1:0] Read_data_2;
  logic             Mthi;
  logic             Mtlo;
  logic             Hilo_read;
  logic [WIDTH-1:0] Hi_out;
  logic [WIDTH-1:0] Lo_out;
  logic             Busy;
  logic             Md_done;
  logic             Div_zero;
  logic             Md_stall;

  modport master (
    output Md_start, Md_op, Read_data_1, Read_data_2, Mthi, Mtlo, Hilo_read,
    input  Hi_out, Lo_out, Busy, Md_done, Div_zero, Md_stall
  );

  modport slave (
    input  Md_start, Md_op, Read_data_1, Read_data_2, Mthi, Mtlo, Hilo_read,
    output Hi_out, Lo_out, Busy, Md_done, Div_zero, Md_stall
  );
endinterface

`default_nettype wire

// File: rtl/md_sequencer.sv
// ============================================================================
// Module   : md_sequencer
// Purpose  : Iterative shift-add multiply / restoring divide controller that
//            owns HI/LO. Optional macro MD_EARLY_OUT_EN shortens multiplies
//            once the remaining multiplier bits are zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module md_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  wire logic     clock,
  input  wire logic     reset,
  md_sequencer_if.slave md
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_last = CNT_W'(WIDTH - 1);

  state_t               r_state;
  state_t               w_next_state;
  logic [2*WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]     r_opnd;
  logic [CNT_W-1:0]     r_cnt;
  logic                 r_is_div;
  logic                 r_neg_res;
  logic                 r_neg_rem;
  logic [WIDTH-1:0]     r_hi;
  logic [WIDTH-1:0]     r_lo;
  logic                 r_done;
  logic                 r_div_zero;

  logic                 w_busy;
  logic                 w_start_ok;
  logic                 w_div_zero_req;
  logic                 w_a_neg;
  logic                 w_b_neg;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic                 w_run_last;
  logic [WIDTH:0]       w_mult_sum;
  logic [2*WIDTH-1:0]   w_mult_step;
  logic [WIDTH:0]       w_trial;
  logic [2*WIDTH-1:0]   w_div_step;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_quot;
  logic [WIDTH-1:0]     w_rem;
  logic [WIDTH-1:0]     w_fix_hi;
  logic [WIDTH-1:0]     w_fix_lo;

  assign w_busy         = (r_state != S_IDLE);
  assign w_start_ok     = md.Md_start & ~w_busy;
  assign w_div_zero_req = w_start_ok & md.Md_op[1] & (md.Read_data_2 == '0);

  // Md_op[0] selects unsigned; signed ops run on magnitudes and fix signs last
  assign w_a_neg = ~md.Md_op[0] & md.Read_data_1[WIDTH-1];
  assign w_b_neg = ~md.Md_op[0] & md.Read_data_2[WIDTH-1];
  assign w_a_mag = w_a_neg ? -md.Read_data_1 : md.Read_data_1;
  assign w_b_mag = w_b_neg ? -md.Read_data_2 : md.Read_data_2;

  assign w_run_last = (r_cnt == c_last);

  // Multiply: acc = {partial product, unshifted multiplier}, carry kept on shift
  assign w_mult_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opnd : '0)};
  assign w_mult_step = {w_mult_sum, r_acc[WIDTH-1:1]};

  // Divide: acc = {remainder, quotient}; the trial uses WIDTH+1 remainder bits
  assign w_trial    = r_acc[2*WIDTH-1:WIDTH-1] - {1'b0, r_opnd};
  assign w_div_step = w_trial[WIDTH] ? {r_acc[2*WIDTH-2:0], 1'b0}
                                     : {w_trial[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

  assign w_prod   = r_neg_res ? -r_acc : r_acc;
  assign w_quot   = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem    = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];
  assign w_fix_hi = r_is_div ? w_rem  : w_prod[2*WIDTH-1:WIDTH];
  assign w_fix_lo = r_is_div ? w_quot : w_prod[WIDTH-1:0];

`ifdef MD_EARLY_OUT_EN
  localparam logic [CNT_W:0] c_width = (CNT_W + 1)'(WIDTH);

  logic [WIDTH-1:0]   w_rem_mask;
  logic               w_mul_idle;
  logic [CNT_W:0]     w_shamt;
  logic [2*WIDTH-1:0] w_early_acc;

  assign w_rem_mask  = {WIDTH{1'b1}} >> r_cnt;
  assign w_mul_idle  = ~r_is_div & ((r_acc[WIDTH-1:0] & w_rem_mask) == '0);
  assign w_shamt     = c_width - {1'b0, r_cnt};
  assign w_early_acc = r_acc >> w_shamt;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_ok && !w_div_zero_req) w_next_state = S_RUN;
      end
      S_RUN: begin
`ifdef MD_EARLY_OUT_EN
        if (w_run_last || w_mul_idle) w_next_state = S_FIX;
`else
        if (w_run_last) w_next_state = S_FIX;
`endif
      end
      S_FIX:   w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc      <= '0;
      r_opnd     <= '0;
      r_cnt      <= '0;
      r_is_div   <= 1'b0;
      r_neg_res  <= 1'b0;
      r_neg_rem  <= 1'b0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_done     <= 1'b0;
      r_div_zero <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_ok) begin
            // a start wins over any coincident mthi/mtlo
            r_div_zero <= w_div_zero_req;
            r_done     <= w_div_zero_req;
            if (!w_div_zero_req) begin
              r_acc     <= md.Md_op[1] ? {{WIDTH{1'b0}}, w_a_mag} : {{WIDTH{1'b0}}, w_b_mag};
              r_opnd    <= md.Md_op[1] ? w_b_mag : w_a_mag;
              r_cnt     <= '0;
              r_is_div  <= md.Md_op[1];
              r_neg_res <= w_a_neg ^ w_b_neg;
              r_neg_rem <= w_a_neg;
            end
          end else begin
            if (md.Mthi) r_hi <= md.Read_data_1;
            if (md.Mtlo) r_lo <= md.Read_data_1;
          end
        end
        S_RUN: begin
          r_cnt <= r_cnt + 1'b1;
`ifdef MD_EARLY_OUT_EN
          if (w_mul_idle)    r_acc <= w_early_acc;
          else if (r_is_div) r_acc <= w_div_step;
          else               r_acc <= w_mult_step;
`else
          r_acc <= r_is_div ? w_div_step : w_mult_step;
`endif
        end
        S_FIX: begin
          r_hi   <= w_fix_hi;
          r_lo   <= w_fix_lo;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign md.Hi_out   = r_hi;
  assign md.Lo_out   = r_lo;
  assign md.Busy     = w_busy;
  assign md.Md_done  = r_done;
  assign md.Div_zero = r_div_zero;
  assign md.Md_stall = w_busy & (md.Md_start | md.Hilo_read | md.Mthi | md.Mtlo);

endmodule

`default_nettype wire

// File: tb/tb_md_sequencer.sv
// ============================================================================
// Module   : tb_md_sequencer
// Purpose  : Self-checking bench for md_sequencer against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_md_sequencer;

  localparam int c_width = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_sequencer_if #(.WIDTH(c_width)) bus ();

  md_sequencer #(.WIDTH(c_width), .CNT_W(6)) dut (
    .clock (clock),
    .reset (reset),
    .md    (bus)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_latency(input logic [1:0] op, input logic [31:0] b);
    logic [31:0] mag;
    int          hb;
    if (op[1] && b == 32'h0) return 1;
`ifdef MD_EARLY_OUT_EN
    if (!op[1]) begin
      mag = (!op[0] && b[31]) ? -b : b;
      hb  = -1;
      for (int i = 0; i < 32; i++) if (mag[i]) hb = i;
      if (hb < 0)        return 3;
      else if (hb == 31) return 34;
      else               return hb + 4;
    end
`else
    mag = b;
    hb  = 0;
`endif
    return c_width + 2;
  endfunction

  // disturb: fire stalled requests mid-run; mt_too: mthi/mtlo alongside start
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit disturb, input bit mt_too);
    logic [63:0] p;
    longint      sa, sb, q, r;
    logic [31:0] e_hi, e_lo;
    bit          dz;
    int          lat, busy_n, done_at;

    dz   = op[1] && (b == 32'h0);
    e_hi = m_hi;
    e_lo = m_lo;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    case (op)
      2'b00: begin p = sa * sb; e_hi = p[63:32]; e_lo = p[31:0]; end
      2'b01: begin p = {32'h0, a} * {32'h0, b}; e_hi = p[63:32]; e_lo = p[31:0]; end
      2'b10: if (!dz) begin q = sa / sb; r = sa % sb; e_lo = q[31:0]; e_hi = r[31:0]; end
      default: if (!dz) begin e_lo = a / b; e_hi = a % b; end
    endcase
    lat = exp_latency(op, b);

    bus.Md_op       = op;
    bus.Read_data_1 = a;
    bus.Read_data_2 = b;
    bus.Md_start    = 1'b1;
    bus.Mthi        = mt_too;
    bus.Mtlo        = mt_too;
    @(posedge clock); #1;
    bus.Md_start = 1'b0;
    bus.Mthi     = 1'b0;
    bus.Mtlo     = 1'b0;
    chk("div_zero_flag", bus.Div_zero, dz);

    busy_n  = 0;
    done_at = 0;
    for (int c = 1; c <= 100 && done_at == 0; c++) begin
      if (disturb && c >= 5 && c <= 9) begin
        bus.Md_start  = (c == 5);
        bus.Hilo_read = (c == 6);
        bus.Mtlo      = (c == 7);
        bus.Mthi      = (c == 8);
        bus.Md_op       = ~op;
        bus.Read_data_1 = $urandom;
        bus.Read_data_2 = $urandom;
        #1;
        chk("stall_during_run", bus.Md_stall, (c != 9));
      end
      if (bus.Busy)    busy_n++;
      if (bus.Md_done) done_at = c;
      else begin
        @(posedge clock); #1;
      end
    end
    chk("done_latency", done_at, lat);
    chk("busy_cycles", busy_n, lat - 1);
    chk("hi_result", bus.Hi_out, e_hi);
    chk("lo_result", bus.Lo_out, e_lo);
    m_hi = e_hi;
    m_lo = e_lo;
    @(posedge clock); #1;
    chk("done_one_pulse", bus.Md_done, 0);
  endtask

  task automatic mt_write(input bit hi_en, input bit lo_en, input logic [31:0] d);
    bus.Read_data_1 = d;
    bus.Mthi        = hi_en;
    bus.Mtlo        = lo_en;
    bus.Hilo_read   = 1'b1;
    #1;
    chk("mt_old_hi", bus.Hi_out, m_hi);
    chk("mt_old_lo", bus.Lo_out, m_lo);
    chk("no_stall_idle", bus.Md_stall, 0);
    @(posedge clock); #1;
    bus.Mthi      = 1'b0;
    bus.Mtlo      = 1'b0;
    bus.Hilo_read = 1'b0;
    if (hi_en) m_hi = d;
    if (lo_en) m_lo = d;
    chk("mt_new_hi", bus.Hi_out, m_hi);
    chk("mt_new_lo", bus.Lo_out, m_lo);
  endtask

  initial begin
    int seen;
    bus.Md_start    = 1'b0;
    bus.Md_op       = 2'b00;
    bus.Read_data_1 = '0;
    bus.Read_data_2 = '0;
    bus.Mthi        = 1'b0;
    bus.Mtlo        = 1'b0;
    bus.Hilo_read   = 1'b0;

    #22;
    chk("rst_hi", bus.Hi_out, 0);
    chk("rst_lo", bus.Lo_out, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_done", bus.Md_done, 0);
    chk("rst_div_zero", bus.Div_zero, 0);
    chk("rst_stall", bus.Md_stall, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;

    run_op(2'b00, 32'd7, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
    run_op(2'b00, 32'd5, 32'd1, 1'b0, 1'b0);

    mt_write(1'b1, 1'b0, 32'h11);
    mt_write(1'b0, 1'b1, 32'h22);
    run_op(2'b10, 32'd5, 32'd0, 1'b0, 1'b0);
    run_op(2'b11, 32'd100, 32'd7, 1'b1, 1'b0);
    mt_write(1'b1, 1'b0, 32'hABCD);
    mt_write(1'b1, 1'b1, 32'h5A5A_1234);
    run_op(2'b01, 32'd9, 32'd6, 1'b0, 1'b1);

    // asynchronous reset in the middle of RUN
    bus.Md_op = 2'b01; bus.Read_data_1 = 32'h12345; bus.Read_data_2 = 32'h777;
    bus.Md_start = 1'b1;
    @(posedge clock); #1;
    bus.Md_start = 1'b0;
    repeat (9) begin @(posedge clock); #1; end
    #2 reset = 1'b0;
    #1;
    chk("abort_busy", bus.Busy, 0);
    chk("abort_hi", bus.Hi_out, 0);
    chk("abort_lo", bus.Lo_out, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    m_hi = '0;
    m_lo = '0;
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.Md_done || bus.Busy) seen++;
      @(posedge clock); #1;
    end
    chk("abort_quiet", seen, 0);
    run_op(2'b00, 32'd3, 32'd4, 1'b0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 5))
        0: b = '0;
        1: b = 32'($urandom_range(0, 255));
        2: a = 32'h8000_0000;
        default: ;
      endcase
      run_op(op, a, b, ($urandom_range(0, 3) == 0) && op[1], 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
